// File: rtl/spi_bus_arbiter.sv
// Two-requester round-robin arbiter for the SPI slave register port, with a
// bounded lock that lets one requester keep the port for multi-word bursts.
module spi_bus_arbiter #(
  parameter int unsigned HOLD_MAX = 16
) (
  input  logic        Clk,
  input  logic        reset,
  input  logic        req0,
  input  logic        req1,
  input  logic        lock0,
  input  logic        lock1,
  input  logic        we0,
  input  logic        we1,
  input  logic [31:0] addr0,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata0,
  input  logic [31:0] wdata1,
  output logic        ack0,
  output logic        ack1,
  output logic [31:0] rdata0,
  output logic [31:0] rdata1,
  output logic        Data_WE,
  output logic [31:0] Data_Addr,
  output logic [31:0] Data_Write,
  input  logic [31:0] Data_Read,
  output logic        owner,
  output logic        busy
);

  localparam int unsigned CW = $clog2(HOLD_MAX + 1);
  localparam logic [CW-1:0] HOLD_LIM = CW'(HOLD_MAX);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ACC  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]    state_q, state_d;
  logic          owner_q, owner_d;
  logic          ptr_q, ptr_d;      // requester favoured on the next tie
  logic [CW-1:0] burst_q, burst_d;
  logic [31:0]   rdata0_q, rdata0_d;
  logic [31:0]   rdata1_q, rdata1_d;

  logic req_own, lock_own, win;

  assign req_own  = owner_q ? req1  : req0;
  assign lock_own = owner_q ? lock1 : lock0;

  // NOTE: every signal assigned below gets a default first, so no path
  // through the case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    ptr_d    = ptr_q;
    burst_d  = burst_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    win      = owner_q;

    case (state_q)
      ST_ACC: begin
        // Reads and writes both capture, so a write returns the slave's view.
        if (owner_q) rdata1_d = Data_Read;
        else         rdata0_d = Data_Read;
        state_d = ST_DONE;
      end
      default: begin
        if (req0 || req1) begin
          if (req0 && req1) begin
            if (state_q == ST_DONE && req_own && lock_own && burst_q < HOLD_LIM)
              win = owner_q;
            else
              win = ptr_q;
          end else begin
            win = req1;
          end
          owner_d = win;
          ptr_d   = ~win;
          state_d = ST_ACC;
          // A grant from IDLE starts a fresh burst; only DONE re-grants count.
          if (state_q == ST_DONE && win == owner_q && lock_own)
            burst_d = (burst_q == HOLD_LIM) ? burst_q : burst_q + CW'(1);
          else
            burst_d = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge Clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      owner_q  <= 1'b0;
      ptr_q    <= 1'b0;
      burst_q  <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      ptr_q    <= ptr_d;
      burst_q  <= burst_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  // Reset is gated in so a write caught mid-access never reaches the slave.
  assign Data_WE    = (state_q == ST_ACC) & (owner_q ? we1 : we0) & ~reset;
  assign Data_Addr  = owner_q ? addr1  : addr0;
  assign Data_Write = owner_q ? wdata1 : wdata0;

  assign ack0   = (state_q == ST_DONE) & ~owner_q;
  assign ack1   = (state_q == ST_DONE) &  owner_q;
  assign rdata0 = rdata0_q;
  assign rdata1 = rdata1_q;
  assign owner  = owner_q;
  assign busy   = (state_q == ST_ACC);

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Directed bench for spi_bus_arbiter: single access, round-robin, bounded
// lock, reset during access and back-to-back accesses from one requester.
module tb_spi_bus_arbiter;

  logic        Clk = 1'b0;
  logic        reset;
  logic        req0, req1, lock0, lock1, we0, we1;
  logic [31:0] addr0, addr1, wdata0, wdata1;
  logic        ack0, ack1;
  logic [31:0] rdata0, rdata1;
  logic        Data_WE;
  logic [31:0] Data_Addr, Data_Write, Data_Read;
  logic        owner, busy;

  int n_checks = 0;
  int n_errors = 0;

  spi_bus_arbiter #(.HOLD_MAX(16)) dut (
    .Clk(Clk), .reset(reset),
    .req0(req0), .req1(req1), .lock0(lock0), .lock1(lock1),
    .we0(we0), .we1(we1), .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
    .Data_WE(Data_WE), .Data_Addr(Data_Addr), .Data_Write(Data_Write),
    .Data_Read(Data_Read), .owner(owner), .busy(busy)
  );

  always #5 Clk = ~Clk;

  // Slave model: register file reads back its own address.
  assign Data_Read = Data_Addr;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1;
    {req0, req1, lock0, lock1, we0, we1} = '0;
    addr0 = 32'h44; wdata0 = 32'h55;
    addr1 = 32'h0;  wdata1 = 32'h0;
    tick();
    chk1("rst_ack0", ack0, 1'b0);
    chk1("rst_ack1", ack1, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_owner", owner, 1'b0);
    chk1("rst_we", Data_WE, 1'b0);
    chk32("rst_rdata0", rdata0, 32'h0);
    chk32("rst_rdata1", rdata1, 32'h0);
    chk32("rst_addr_follows0", Data_Addr, 32'h44);
    chk32("rst_wdata_follows0", Data_Write, 32'h55);

    // Single write from requester 0.
    reset = 1'b0;
    req0 = 1'b1; we0 = 1'b1; addr0 = 32'h04; wdata0 = 32'hDEADBEEF;
    tick();
    chk1("wr_acc_we", Data_WE, 1'b1);
    chk32("wr_acc_addr", Data_Addr, 32'h04);
    chk32("wr_acc_wdata", Data_Write, 32'hDEADBEEF);
    chk1("wr_acc_busy", busy, 1'b1);
    chk1("wr_acc_ack0", ack0, 1'b0);
    tick();
    chk1("wr_done_ack0", ack0, 1'b1);
    chk1("wr_done_ack1", ack1, 1'b0);
    chk1("wr_done_we", Data_WE, 1'b0);
    chk32("wr_done_rdata0", rdata0, 32'h04);
    req0 = 1'b0; we0 = 1'b0;
    tick();
    chk1("wr_idle_ack0", ack0, 1'b0);
    chk1("wr_idle_ack1", ack1, 1'b0);
    chk1("wr_idle_busy", busy, 1'b0);

    // Simultaneous reads straight out of reset.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    req0 = 1'b1; addr0 = 32'h10;
    req1 = 1'b1; addr1 = 32'h20;
    tick();
    chk1("rr_first_owner", owner, 1'b0);
    tick();
    chk1("rr_ack0_first", ack0, 1'b1);
    chk1("rr_ack1_not_first", ack1, 1'b0);
    chk32("rr_rdata0", rdata0, 32'h10);
    tick();
    chk1("rr_second_owner", owner, 1'b1);
    chk32("rr_second_addr", Data_Addr, 32'h20);
    tick();
    chk1("rr_ack1_second", ack1, 1'b1);
    chk1("rr_ack0_second", ack0, 1'b0);
    chk32("rr_rdata1", rdata1, 32'h20);
    chk32("rr_rdata0_held", rdata0, 32'h10);
    for (int k = 0; k < 4; k++) begin
      tick();
      tick();
      chk1($sformatf("rr_alt_ack0_%0d", k), ack0, (k % 2) == 0);
      chk1($sformatf("rr_alt_ack1_%0d", k), ack1, (k % 2) == 1);
    end
    req0 = 1'b0; req1 = 1'b0;
    tick();
    chk1("rr_idle_busy", busy, 1'b0);

    // Bounded lock: requester 1 bursts, requester 0 waits.
    req1 = 1'b1; lock1 = 1'b1; addr1 = 32'h30;
    tick();
    req0 = 1'b1; addr0 = 32'h40;
    tick();
    chk1("lk_ack1_1", ack1, 1'b1);
    for (int i = 2; i <= 17; i++) begin
      tick();
      tick();
      chk1($sformatf("lk_ack1_%0d", i), ack1, 1'b1);
      chk1($sformatf("lk_ack0_%0d", i), ack0, 1'b0);
    end
    tick();
    chk32("lk_other_addr", Data_Addr, 32'h40);
    tick();
    chk1("lk_ack0_after_17", ack0, 1'b1);
    chk1("lk_ack1_after_17", ack1, 1'b0);
    tick();
    tick();
    chk1("lk_ack1_resumes", ack1, 1'b1);
    req0 = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      chk1($sformatf("lk_solo_busy_%0d", i), busy, 1'b1);
      tick();
      chk1($sformatf("lk_solo_ack1_%0d", i), ack1, 1'b1);
    end
    // Count is saturated here, so a new req0 must win over the locked owner.
    req0 = 1'b1;
    tick();
    tick();
    chk1("lk_sat_ack0", ack0, 1'b1);
    chk1("lk_sat_ack1", ack1, 1'b0);
    req0 = 1'b0; req1 = 1'b0; lock1 = 1'b0;
    tick();
    chk1("lk_idle_busy", busy, 1'b0);

    // Reset pulsed during the access cycle of a write.
    req0 = 1'b1; we0 = 1'b1; addr0 = 32'h08; wdata0 = 32'h12345678;
    tick();
    chk1("rs_acc_we_before", Data_WE, 1'b1);
    reset = 1'b1; req0 = 1'b0;
    #1;
    chk1("rs_acc_we_gated", Data_WE, 1'b0);
    tick();
    chk1("rs_ack0", ack0, 1'b0);
    chk1("rs_ack1", ack1, 1'b0);
    chk1("rs_busy", busy, 1'b0);
    chk32("rs_rdata0", rdata0, 32'h0);
    chk32("rs_rdata1", rdata1, 32'h0);
    reset = 1'b0; we0 = 1'b0;
    tick();
    chk1("rs_post_ack0", ack0, 1'b0);
    chk1("rs_post_busy", busy, 1'b0);

    // One requester, new address presented in each ack cycle.
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'h00;
    for (int j = 0; j < 3; j++) begin
      tick();
      chk32($sformatf("b2b_addr_%0d", j), Data_Addr, 32'(j * 4));
      chk1($sformatf("b2b_acc_ack0_%0d", j), ack0, 1'b0);
      tick();
      chk1($sformatf("b2b_ack0_%0d", j), ack0, 1'b1);
      chk32($sformatf("b2b_rdata0_%0d", j), rdata0, 32'(j * 4));
      addr0 = 32'((j + 1) * 4);
      if (j == 2) req0 = 1'b0;
    end
    tick();
    chk1("b2b_idle_ack0", ack0, 1'b0);
    chk1("b2b_idle_busy", busy, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/spi_bus_arbiter.md
# spi_bus_arbiter

Two-requester arbiter sharing the SPI slave's memory-mapped register port (Data_WE/Data_Addr/Data_Write/Data_Read) between the ARM data bus (requester 0) and a hardware engine (requester 1). It serialises single-word accesses with round-robin fairness and supports a bounded lock for multi-word bursts. It sits between the processor's memory decoder and the SPI slave, on the same clock as the slave.

## Interface
- HOLD_MAX, 16: max consecutive locked grants to one owner while the other requester waits (≥1).
- Clk  input  1  system clock; all logic on posedge.
- reset  input  1  synchronous, active-high.
- req0, req1  input  1 each  access request.
- lock0, lock1  input  1 each  request to keep grant for the next access.
- we0, we1  input  1 each  1 = write, 0 = read.
- addr0, addr1  input  32 each  word address (slave decodes [5:2]).
- wdata0, wdata1  input  32 each  write data.
- ack0, ack1  output  1 each  one-cycle completion pulse.
- rdata0, rdata1  output  32 each  read data, valid while ackN=1.
- Data_WE  output  1  slave write enable.
- Data_Addr  output  32  slave address.
- Data_Write  output  32  slave write data.
- Data_Read  input  32  slave read data (combinational from Data_Addr).
- owner  output  1  current/last granted requester.
- busy  output  1  state is ACC.

## Operation
- States: IDLE, ACC, DONE. Arbitration is evaluated in IDLE and DONE (identical decision); ACC performs the access.
- Decision: no req → IDLE. One req → that requester. Both → lock-hold rule, else round-robin pointer (priority to the requester not granted last). Winner latched into owner; next state ACC.
- Lock-hold: in DONE, if req[owner]=1, lock[owner]=1 and burst_cnt<HOLD_MAX, owner wins regardless of the other req.
- burst_cnt: reset to 0 when owner changes or lock[owner]=0 at decision; +1 per locked re-grant; saturates at HOLD_MAX. At HOLD_MAX with other req pending → other wins. With other idle → owner continues, count stays saturated.
- ACC: Data_Addr/Data_Write = addr/wdata of owner (muxed combinationally from owner in all states); Data_WE = (state==ACC) & we[owner] & ~reset. rdata[owner] register ← Data_Read at end of ACC (reads and writes both capture). Next state DONE.
- DONE: ack[owner]=1 for exactly this cycle; rdata[owner] stable. The other ack=0.
- Requester handshake: hold req/we/addr/wdata stable from req assertion until ack. req=1 in the ack cycle is a new transaction (fields may change in that cycle); to stop, deassert req in the ack cycle.
- rdata of a non-owner holds last value.

## Timing
- Reset (synchronous): state IDLE, owner=0, pointer favours requester 0, burst_cnt=0, ack0/1=0, rdata0/1=0, busy=0, Data_WE=0 during the reset cycle; Data_Addr/Data_Write follow addr0/wdata0.
- Latency from IDLE: req at cycle t → ACC at t+1 (write commits at end of t+1) → ack at t+2.
- Back-to-back: one access per 2 cycles (ACC, DONE, ACC, ...), no IDLE gap when any req present in DONE.
- Both requesters continuously requesting, no lock: grants alternate 0,1,0,1...
- Reset asserted during ACC: no write issued, no ack, IDLE next cycle.
- Request deasserted before ack: protocol violation; access still completes with values present in ACC.

## Test plan
- Reset then req0 write addr=0x04 wdata=0xDEADBEEF → Data_WE=1 one cycle at t+1 with Data_Addr=0x04; ack0 at t+2; ack1 never.
- Simultaneous req0/req1 reads from reset, Data_Read model returns addr → ack0 first (rdata0=addr0), ack1 two cycles later (rdata1=addr1); then continuous alternation 0,1,0,1.
- req1 lock=1 for 40 accesses with req0 held, HOLD_MAX=16 → 17 consecutive ack1, then one ack0, then ack1 resumes; with req0 idle, all 40 ack1 back-to-back every 2 cycles.
- reset pulsed during ACC of a write → Data_WE stays 0 that cycle, no ack, state IDLE, rdata0/1=0.
- Single requester keeps req high with changing addr in each ack cycle (0x00,0x04,0x08) → three accesses at those addresses, acks at t+2, t+4, t+6.
